// File: rtl/glitch_sweep_if.sv
// Host/target-facing signal bundle of the glitch delay-sweep sequencer.
// The master side drives commands, config and trigger; the slave side is the sequencer.
interface glitch_sweep_if;
    logic        start;
    logic        abort;
    logic [31:0] cfg_delay_start;
    logic [31:0] cfg_delay_end;
    logic [31:0] cfg_delay_step;
    logic [15:0] cfg_repeats;
    logic        trigger;
    logic [31:0] delay_cycles;
    logic        set_delay;
    logic        arm;
    logic        target_rst;
    logic        busy;
    logic        attempt_valid;
    logic [31:0] attempt_delay;
    logic        attempt_timeout;
    logic        done;

    modport master (
        output start, abort, cfg_delay_start, cfg_delay_end, cfg_delay_step, cfg_repeats, trigger,
        input  delay_cycles, set_delay, arm, target_rst, busy,
               attempt_valid, attempt_delay, attempt_timeout, done
    );

    modport slave (
        input  start, abort, cfg_delay_start, cfg_delay_end, cfg_delay_step, cfg_repeats, trigger,
        output delay_cycles, set_delay, arm, target_rst, busy,
               attempt_valid, attempt_delay, attempt_timeout, done
    );
endinterface

// File: rtl/glitch_sweep_ctrl.sv
// Delay-sweep sequencer: per attempt it loads a delay, resets the target, arms for the
// trigger, waits out the glitch window and cooldown, reports, then steps the delay.
module glitch_sweep_ctrl #(
    parameter int RST_CYCLES      = 48,
    parameter int TIMEOUT_CYCLES  = 480000,
    parameter int GLITCH_WAIT     = 64,
    parameter int COOLDOWN_CYCLES = 4800
) (
    input  logic          clk,
    input  logic          rst,
    glitch_sweep_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, TRST, ARM, GWAIT, COOL, NEXT, DONE} state_t;

    // Timed states count 0..N-1 and leave on the last count, so each lasts exactly N cycles.
    localparam logic [31:0] RST_LAST     = 32'(RST_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] GLITCH_LAST  = 32'(GLITCH_WAIT - 1);
    localparam logic [31:0] COOL_LAST    = 32'(COOLDOWN_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q;
    logic [31:0] cur_delay_q;
    logic [31:0] end_q;
    logic [31:0] step_q;
    logic [15:0] reps_q;
    logic [15:0] rep_cnt_q;
    logic        timeout_q;

    logic [32:0] next_sum;
    logic [16:0] reps_eff;
    logic        more_reps;
    logic        sweep_last;
    logic        timed;

    // The 33-bit sum exposes the carry so a wrapping step ends the sweep instead of restarting low.
    assign next_sum   = {1'b0, cur_delay_q} + {1'b0, step_q};
    assign reps_eff   = (reps_q == 16'd0) ? 17'd1 : {1'b0, reps_q};
    assign more_reps  = ({1'b0, rep_cnt_q} + 17'd1) < reps_eff;
    assign sweep_last = (step_q == 32'd0) || next_sum[32] || (next_sum[31:0] > end_q);
    assign timed      = (state_q == TRST) || (state_q == ARM) || (state_q == GWAIT) || (state_q == COOL);

    // NOTE: sequential state is written with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every variable driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.start && !bus.abort)
                       state_d = (bus.cfg_delay_start > bus.cfg_delay_end) ? DONE : LOAD;
            LOAD:  state_d = TRST;
            TRST:  if (cnt_q == RST_LAST) state_d = ARM;
            ARM:   if (bus.trigger)                state_d = GWAIT;
                   else if (cnt_q == TIMEOUT_LAST) state_d = COOL;
            GWAIT: if (cnt_q == GLITCH_LAST) state_d = COOL;
            COOL:  if (cnt_q == COOL_LAST) state_d = NEXT;
            NEXT:  state_d = (more_reps || !sweep_last) ? LOAD : DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.abort && (state_q != IDLE)) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            cur_delay_q <= '0;
            end_q       <= '0;
            step_q      <= '0;
            reps_q      <= '0;
            rep_cnt_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (state_d != state_q) cnt_q <= '0;
            else if (timed)         cnt_q <= cnt_q + 32'd1;

            case (state_q)
                IDLE: if (bus.start && !bus.abort) begin
                    cur_delay_q <= bus.cfg_delay_start;
                    end_q       <= bus.cfg_delay_end;
                    step_q      <= bus.cfg_delay_step;
                    reps_q      <= bus.cfg_repeats;
                    rep_cnt_q   <= '0;
                end
                ARM: begin
                    if (bus.trigger)                timeout_q <= 1'b0;
                    else if (cnt_q == TIMEOUT_LAST) timeout_q <= 1'b1;
                end
                // An abort here still reports the attempt but must not move delay_cycles.
                NEXT: if (!bus.abort) begin
                    if (more_reps) begin
                        rep_cnt_q <= rep_cnt_q + 16'd1;
                    end else begin
                        rep_cnt_q <= '0;
                        if (!sweep_last) cur_delay_q <= next_sum[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.delay_cycles    = cur_delay_q;
        bus.set_delay       = 1'b0;
        bus.target_rst      = 1'b0;
        bus.arm             = 1'b0;
        bus.attempt_valid   = 1'b0;
        bus.attempt_delay   = '0;
        bus.attempt_timeout = 1'b0;
        bus.done            = 1'b0;
        bus.busy            = (state_q != IDLE) && (state_q != DONE);
        case (state_q)
            LOAD: bus.set_delay  = 1'b1;
            TRST: bus.target_rst = 1'b1;
            ARM:  bus.arm        = 1'b1;
            NEXT: begin
                bus.attempt_valid   = 1'b1;
                bus.attempt_delay   = cur_delay_q;
                bus.attempt_timeout = timeout_q;
            end
            DONE: bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// Bench for glitch_sweep_ctrl: each sweep is expanded from the sweep rules into a per-cycle
// trace of stimulus plus expected outputs, which is then played and compared cycle by cycle.
module tb_glitch_sweep_ctrl;
    localparam int RST_C = 3;
    localparam int TO_C  = 100;
    localparam int GW_C  = 4;
    localparam int CD_C  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    glitch_sweep_if bus ();

    glitch_sweep_ctrl #(
        .RST_CYCLES     (RST_C),
        .TIMEOUT_CYCLES (TO_C),
        .GLITCH_WAIT    (GW_C),
        .COOLDOWN_CYCLES(CD_C)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit          chk;
        bit          rst_req;
        bit          start;
        bit          abort;
        bit          trig;
        logic [31:0] cs, ce, cst;
        logic [15:0] cr;
        bit          sd;
        logic [31:0] dc;
        bit          trst, arm_e, busy, av;
        logic [31:0] ad;
        bit          at, done;
    } cyc_t;

    cyc_t        tq[$];
    cyc_t        sq[$];
    int          trig_plan[$];
    logic [31:0] m_delay = '0;

    int checks = 0;
    int errors = 0;

    int          obs_sd, obs_av, obs_done, obs_arm, obs_to;
    logic [31:0] obs_sd_d[$];
    logic [31:0] obs_av_d[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic cyc_t blank(input logic [31:0] dc);
        cyc_t c;
        c     = '{default: '0};
        c.chk = 1'b1;
        c.dc  = dc;
        c.cs  = $urandom;
        c.ce  = $urandom;
        c.cst = $urandom;
        c.cr  = 16'($urandom);
        return c;
    endfunction

    // One cycle of a running sweep; triggers outside arm are random noise the DUT must ignore.
    task automatic emit(input logic [31:0] d, input bit sd, input bit trst, input bit arm_in,
                        input bit av, input bit at, input bit trig_in);
        cyc_t c;
        c       = blank(d);
        c.busy  = 1'b1;
        c.sd    = sd;
        c.trst  = trst;
        c.arm_e = arm_in;
        c.av    = av;
        c.ad    = av ? d : 32'd0;
        c.at    = at;
        c.start = ($urandom_range(0, 3) == 0);
        c.trig  = arm_in ? trig_in : ($urandom_range(0, 7) == 0);
        sq.push_back(c);
    endtask

    // t < 0: no trigger (timeout); otherwise trigger on arm cycle t.
    task automatic emit_attempt(input logic [31:0] d);
        int t;
        int n;
        int r;
        bit hit;
        if (trig_plan.size() > 0) t = trig_plan.pop_front();
        else begin
            r = $urandom_range(0, 9);
            if (r < 2)       t = -1;
            else if (r == 2) t = TO_C - 1;
            else             t = $urandom_range(0, 15);
        end
        hit = (t >= 0);
        n   = hit ? t + 1 : TO_C;
        emit(d, 1, 0, 0, 0, 0, 0);
        repeat (RST_C) emit(d, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) emit(d, 0, 0, 1, 0, 0, hit && (i == n - 1));
        if (hit) repeat (GW_C) emit(d, 0, 0, 0, 0, 0, 0);
        repeat (CD_C) emit(d, 0, 0, 0, 0, 0, 0);
        emit(d, 0, 0, 0, 1, !hit, 0);
    endtask

    task automatic idle_cycles(input int n);
        cyc_t c;
        repeat (n) begin
            c      = blank(m_delay);
            c.trig = ($urandom_range(0, 1) == 1);
            tq.push_back(c);
        end
    endtask

    // Expands one sweep into sq; cut > 0 places an abort (or rst) on that trace offset.
    task automatic gen_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                             input logic [15:0] r, input int cut, input bit cut_rst,
                             output int len);
        cyc_t            c;
        longint unsigned d;
        int              reps;
        int              a;
        bit              more;
        sq.delete();
        c       = blank(m_delay);
        c.start = 1'b1;
        c.cs    = s;
        c.ce    = e;
        c.cst   = st;
        c.cr    = r;
        sq.push_back(c);
        reps = (r == 16'd0) ? 1 : int'(r);
        d    = longint'(s);
        if (s <= e) begin
            more = 1'b1;
            while (more) begin
                for (int k = 0; k < reps; k++) emit_attempt(32'(d));
                if ((st == 32'd0) || (d + longint'(st) > longint'(e))) more = 1'b0;
                else d = d + longint'(st);
            end
        end
        c       = blank(32'(d));
        c.done  = 1'b1;
        c.start = ($urandom_range(0, 1) == 1);
        sq.push_back(c);
        if (cut > 0) begin
            a = (cut < sq.size()) ? cut : sq.size() - 1;
            if (cut_rst) sq[a].rst_req = 1'b1;
            else         sq[a].abort   = 1'b1;
            while (sq.size() > a + 1) void'(sq.pop_back());
            m_delay = cut_rst ? 32'd0 : sq[a].dc;
        end else begin
            m_delay = sq[sq.size() - 1].dc;
        end
        len = sq.size();
        foreach (sq[i]) tq.push_back(sq[i]);
        idle_cycles(2);
    endtask

    task automatic obs_clear;
        obs_sd = 0; obs_av = 0; obs_done = 0; obs_arm = 0; obs_to = 0;
        obs_sd_d.delete();
        obs_av_d.delete();
    endtask

    task automatic run_trace;
        cyc_t c;
        while (tq.size() > 0) begin
            c = tq.pop_front();
            @(posedge clk);
            #1;
            rst                 = c.rst_req;
            bus.start           = c.start;
            bus.abort           = c.abort;
            bus.trigger         = c.trig;
            bus.cfg_delay_start = c.cs;
            bus.cfg_delay_end   = c.ce;
            bus.cfg_delay_step  = c.cst;
            bus.cfg_repeats     = c.cr;
            @(negedge clk);
            if (c.chk) begin
                check("set_delay",     32'(bus.set_delay),     32'(c.sd));
                check("delay_cycles",  bus.delay_cycles,       c.dc);
                check("target_rst",    32'(bus.target_rst),    32'(c.trst));
                check("arm",           32'(bus.arm),           32'(c.arm_e));
                check("busy",          32'(bus.busy),          32'(c.busy));
                check("attempt_valid", 32'(bus.attempt_valid), 32'(c.av));
                check("done",          32'(bus.done),          32'(c.done));
                if (c.av) begin
                    check("attempt_delay",   bus.attempt_delay,         c.ad);
                    check("attempt_timeout", 32'(bus.attempt_timeout),  32'(c.at));
                end
            end
            if (bus.set_delay === 1'b1) begin obs_sd++; obs_sd_d.push_back(bus.delay_cycles); end
            if (bus.attempt_valid === 1'b1) begin
                obs_av++;
                obs_av_d.push_back(bus.attempt_delay);
                if (bus.attempt_timeout === 1'b1) obs_to++;
            end
            if (bus.done === 1'b1) obs_done++;
            if (bus.arm === 1'b1)  obs_arm++;
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        cyc_t            c;
        int              len;
        int              cut;
        logic [31:0]     s, e, st;
        longint unsigned el;

        bus.start = 1'b0; bus.abort = 1'b0; bus.trigger = 1'b0;
        bus.cfg_delay_start = '0; bus.cfg_delay_end = '0;
        bus.cfg_delay_step = '0;  bus.cfg_repeats = '0;

        // Reset state
        c = blank(32'd0);
        c.rst_req = 1'b1;
        c.chk     = 1'b0;
        tq.push_back(c);
        idle_cycles(3);
        run_trace();

        // Three delays, trigger 5 cycles into each arm window
        obs_clear();
        trig_plan = '{5, 5, 5};
        gen_sweep(32'd10, 32'd30, 32'd10, 16'd1, 0, 1'b0, len);
        check("t1_model_len", 32'(len), 32'd62);
        run_trace();
        check("t1_sd_count", 32'(obs_sd), 32'd3);
        check("t1_sd_0", qget(obs_sd_d, 0), 32'd10);
        check("t1_sd_1", qget(obs_sd_d, 1), 32'd20);
        check("t1_sd_2", qget(obs_sd_d, 2), 32'd30);
        check("t1_av_count", 32'(obs_av), 32'd3);
        check("t1_timeouts", 32'(obs_to), 32'd0);
        check("t1_done", 32'(obs_done), 32'd1);

        // One delay repeated three times
        obs_clear();
        trig_plan = '{2, 2, 2};
        gen_sweep(32'd5, 32'd5, 32'd1, 16'd3, 0, 1'b0, len);
        run_trace();
        check("t2_sd_count", 32'(obs_sd), 32'd3);
        check("t2_av_count", 32'(obs_av), 32'd3);
        for (int i = 0; i < 3; i++) check("t2_av_delay", qget(obs_av_d, i), 32'd5);
        check("t2_done", 32'(obs_done), 32'd1);

        // Timeout on the first delay, then the sweep carries on
        obs_clear();
        trig_plan = '{-1, 2};
        gen_sweep(32'd0, 32'd1, 32'd1, 16'd1, 0, 1'b0, len);
        run_trace();
        check("t3_arm_cycles", 32'(obs_arm), 32'd103);
        check("t3_timeouts", 32'(obs_to), 32'd1);
        check("t3_av_count", 32'(obs_av), 32'd2);
        check("t3_av_delay1", qget(obs_av_d, 1), 32'd1);

        // Step overflow past 2^32 ends the sweep
        obs_clear();
        trig_plan = '{3};
        gen_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 0, 1'b0, len);
        run_trace();
        check("t4_sd_count", 32'(obs_sd), 32'd1);
        check("t4_av_delay", qget(obs_av_d, 0), 32'hFFFF_FFF0);
        check("t4_done", 32'(obs_done), 32'd1);

        // Empty range: straight to DONE
        obs_clear();
        gen_sweep(32'd8, 32'd4, 32'd1, 16'd1, 0, 1'b0, len);
        check("t5_model_len", 32'(len), 32'd2);
        run_trace();
        check("t5_sd_count", 32'(obs_sd), 32'd0);
        check("t5_av_count", 32'(obs_av), 32'd0);
        check("t5_done", 32'(obs_done), 32'd1);

        // Abort during target reset, rst during arm, then a clean sweep
        obs_clear();
        trig_plan = '{5};
        gen_sweep(32'd10, 32'd30, 32'd10, 16'd1, 2, 1'b0, len);
        trig_plan = '{20};
        gen_sweep(32'd10, 32'd30, 32'd10, 16'd1, 6, 1'b1, len);
        run_trace();
        check("t6_av_count", 32'(obs_av), 32'd0);
        check("t6_done", 32'(obs_done), 32'd0);
        obs_clear();
        trig_plan = '{5, 5, 5};
        gen_sweep(32'd10, 32'd30, 32'd10, 16'd1, 0, 1'b0, len);
        run_trace();
        check("t6_fresh_sd_count", 32'(obs_sd), 32'd3);
        check("t6_fresh_done", 32'(obs_done), 32'd1);

        // start with abort in IDLE is ignored
        obs_clear();
        c       = blank(m_delay);
        c.start = 1'b1;
        c.abort = 1'b1;
        tq.push_back(c);
        idle_cycles(3);
        run_trace();
        check("t7_sd_count", 32'(obs_sd), 32'd0);

        // Randomized sweeps with occasional abort/rst
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 5) == 0) s = 32'hFFFF_FFFF - $urandom_range(0, 40);
            else                           s = $urandom_range(0, 40);
            if ($urandom_range(0, 7) == 0 && s >= 32'd10) e = s - $urandom_range(1, 10);
            else begin
                el = longint'(s) + longint'($urandom_range(0, 30));
                e  = (el > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(el);
            end
            st  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom_range(4, 15);
            cut = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 60) : 0;
            gen_sweep(s, e, st, 16'($urandom_range(0, 3)), cut, ($urandom_range(0, 2) == 0), len);
            run_trace();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
